// File: rtl/memory_map.sv
// CPU-side memory responder: decodes the nibble address space into general RAM,
// dual-bank display RAM and a forwarded I/O window, plus a read-only video port.
module memory_map #(
  parameter int RAM_SIZE       = 640,
  parameter int VRAM_BANK_SIZE = 80,
  parameter int IO_SIZE        = 128
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [11:0] memory_addr,
  input  logic        memory_write_en,
  input  logic [3:0]  memory_write_data,
  output logic [3:0]  memory_read_data,
  output logic [6:0]  io_addr,
  output logic        io_write_en,
  output logic [3:0]  io_write_data,
  output logic        io_read_strobe,
  input  logic [3:0]  io_read_data,
  input  logic [7:0]  video_addr,
  output logic [3:0]  video_data
);

  localparam int VRAM_SIZE = 2 * VRAM_BANK_SIZE;
  localparam int RAM_AW    = $clog2(RAM_SIZE);
  localparam int VRAM_AW   = $clog2(VRAM_SIZE);

  localparam logic [12:0] RAM_END    = 13'(RAM_SIZE);
  localparam logic [12:0] VRAM0_BASE = 13'h0E00;
  localparam logic [12:0] VRAM0_END  = 13'(32'hE00 + VRAM_BANK_SIZE);
  localparam logic [12:0] VRAM1_BASE = 13'h0E80;
  localparam logic [12:0] VRAM1_END  = 13'(32'hE80 + VRAM_BANK_SIZE);
  localparam logic [12:0] IO_BASE    = 13'h0F00;
  localparam logic [12:0] IO_END     = 13'(32'hF00 + IO_SIZE);
  localparam logic [12:0] BANK_OFS   = 13'(VRAM_BANK_SIZE);
  localparam logic [8:0]  VIDEO_END  = 9'(VRAM_SIZE);

  typedef enum logic [1:0] {
    REG_NONE,
    REG_RAM,
    REG_VRAM,
    REG_IO
  } region_t;

  logic [12:0] addr13;
  logic        in_ram;
  logic        in_vram0;
  logic        in_vram1;
  logic        in_vram;
  logic        in_io;
  logic [12:0] vram_lin;
  logic [RAM_AW-1:0]  ram_idx;
  logic [VRAM_AW-1:0] cpu_vram_idx;
  logic [VRAM_AW-1:0] video_idx;
  region_t     region_next;

  assign addr13   = {1'b0, memory_addr};
  assign in_ram   = addr13 < RAM_END;
  assign in_vram0 = (addr13 >= VRAM0_BASE) && (addr13 < VRAM0_END);
  assign in_vram1 = (addr13 >= VRAM1_BASE) && (addr13 < VRAM1_END);
  assign in_vram  = in_vram0 || in_vram1;
  assign in_io    = (addr13 >= IO_BASE) && (addr13 < IO_END);

  // Both banks share one linear array: bank1 sits directly after bank0.
  assign vram_lin     = in_vram1 ? (addr13 - VRAM1_BASE + BANK_OFS) : (addr13 - VRAM0_BASE);
  assign cpu_vram_idx = vram_lin[VRAM_AW-1:0];
  assign ram_idx      = memory_addr[RAM_AW-1:0];
  assign video_idx    = video_addr[VRAM_AW-1:0];

  always_comb begin
    region_next = REG_NONE;
    if (in_ram)       region_next = REG_RAM;
    else if (in_vram) region_next = REG_VRAM;
    else if (in_io)   region_next = REG_IO;
  end

  assign io_addr       = memory_addr[6:0];
  assign io_write_en   = memory_write_en && in_io;
  assign io_write_data = memory_write_data;

  logic [3:0] ram_mem  [RAM_SIZE];
  logic [3:0] vram_mem [VRAM_SIZE];
  logic [3:0] ram_rd_reg;
  logic [3:0] vram_rd_reg;
  logic [3:0] video_rd_reg;

  // Storage and its read registers carry no reset so they map onto block RAM;
  // reading in the same block as the write gives read-first behaviour.
  always_ff @(posedge clk) begin
    if (memory_write_en && in_ram) ram_mem[ram_idx] <= memory_write_data;
    ram_rd_reg <= ram_mem[ram_idx];
  end

  always_ff @(posedge clk) begin
    if (memory_write_en && in_vram) vram_mem[cpu_vram_idx] <= memory_write_data;
    vram_rd_reg <= vram_mem[cpu_vram_idx];
  end

  always_ff @(posedge clk) begin
    video_rd_reg <= vram_mem[video_idx];
  end

  region_t     region_reg;
  logic [3:0]  io_data_reg;
  logic        video_hit_reg;
  logic [11:0] last_addr_reg;
  logic        io_read_strobe_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      region_reg         <= REG_NONE;
      io_data_reg        <= 4'h0;
      video_hit_reg      <= 1'b0;
      last_addr_reg      <= 12'hFFF;
      io_read_strobe_reg <= 1'b0;
    end else begin
      region_reg         <= region_next;
      io_data_reg        <= io_read_data;
      video_hit_reg      <= {1'b0, video_addr} < VIDEO_END;
      last_addr_reg      <= memory_addr;
      io_read_strobe_reg <= (memory_addr != last_addr_reg) && in_io && !memory_write_en;
    end
  end

  // Region tag is reset, so outputs drop to zero as soon as reset asserts.
  always_comb begin
    memory_read_data = 4'h0;
    case (region_reg)
      REG_RAM:  memory_read_data = ram_rd_reg;
      REG_VRAM: memory_read_data = vram_rd_reg;
      REG_IO:   memory_read_data = io_data_reg;
      default:  memory_read_data = 4'h0;
    endcase
  end

  assign video_data     = video_hit_reg ? video_rd_reg : 4'h0;
  assign io_read_strobe = io_read_strobe_reg;

endmodule

// File: tb/tb_memory_map.sv
// Bench for memory_map: directed scenarios plus randomized traffic, all checked
// against an array-based model of the address map.
module tb_memory_map;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] memory_addr;
  logic        memory_write_en;
  logic [3:0]  memory_write_data;
  logic [3:0]  memory_read_data;
  logic [6:0]  io_addr;
  logic        io_write_en;
  logic [3:0]  io_write_data;
  logic        io_read_strobe;
  logic [3:0]  io_read_data;
  logic [7:0]  video_addr;
  logic [3:0]  video_data;

  always #5 clk = ~clk;

  memory_map dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .memory_addr       (memory_addr),
    .memory_write_en   (memory_write_en),
    .memory_write_data (memory_write_data),
    .memory_read_data  (memory_read_data),
    .io_addr           (io_addr),
    .io_write_en       (io_write_en),
    .io_write_data     (io_write_data),
    .io_read_strobe    (io_read_strobe),
    .io_read_data      (io_read_data),
    .video_addr        (video_addr),
    .video_data        (video_data)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: -1 marks a location never written (contents undefined).
  int          ram_m  [640];
  int          vram_m [160];
  logic [11:0] last_m;

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic int vram_index(input int a);
    if (a >= 'hE00 && a < 'hE00 + 80) return a - 'hE00;
    if (a >= 'hE80 && a < 'hE80 + 80) return 80 + a - 'hE80;
    return -1;
  endfunction

  function automatic bit is_io(input int a);
    return (a >= 'hF00) && (a < 'hF00 + 128);
  endfunction

  function automatic int cpu_expect(input int a, input int iod);
    if (a < 640) return ram_m[a];
    if (vram_index(a) >= 0) return vram_m[vram_index(a)];
    if (is_io(a)) return iod;
    return 0;
  endfunction

  // One bus cycle: drive, check combinational I/O outputs, clock, check registered outputs.
  task automatic step(input logic [11:0] a, input logic we, input logic [3:0] wd,
                      input logic [7:0] va, input logic [3:0] iod);
    int   exp_rd;
    int   exp_vd;
    logic exp_strb;
    int   ai;
    int   vi;
    ai = int'(a);
    memory_addr       = a;
    memory_write_en   = we;
    memory_write_data = wd;
    video_addr        = va;
    io_read_data      = iod;
    #1;
    check("io_addr", 12'(io_addr), 12'(ai % 128));
    check("io_write_en", 12'(io_write_en), 12'(we && is_io(ai)));
    check("io_write_data", 12'(io_write_data), 12'(wd));
    exp_rd   = cpu_expect(ai, int'(iod));
    exp_vd   = (int'(va) < 160) ? vram_m[va] : 0;
    exp_strb = (a != last_m) && is_io(ai) && !we;
    @(posedge clk);
    #1;
    if (exp_rd >= 0) check("read_data", 12'(memory_read_data), 12'(exp_rd[3:0]));
    if (exp_vd >= 0) check("video_data", 12'(video_data), 12'(exp_vd[3:0]));
    check("io_read_strobe", 12'(io_read_strobe), 12'(exp_strb));
    last_m = a;
    if (we) begin
      vi = vram_index(ai);
      if (ai < 640) ram_m[ai] = int'(wd);
      else if (vi >= 0) vram_m[vi] = int'(wd);
    end
  endtask

  function automatic logic [11:0] rand_addr();
    int unsigned off;
    off = $urandom_range(0, 7);
    case ($urandom_range(0, 6))
      0: return 12'(off);
      1: return 12'(632 + off);
      2: return 12'('hE00 + ((off < 4) ? off : 72 + off));
      3: return 12'('hE80 + ((off < 4) ? off : 72 + off));
      4: return 12'('hF00 + (off % 4));
      5: return 12'('hE50 + off);
      default: return (off < 3) ? 12'h280 : ((off < 6) ? 12'hF80 : 12'hFFF);
    endcase
  endfunction

  function automatic logic [7:0] rand_vaddr();
    int unsigned off;
    off = $urandom_range(0, 7);
    case ($urandom_range(0, 3))
      0: return 8'(off);
      1: return 8'(76 + off);
      2: return 8'(156 + off);
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 640; i++) ram_m[i] = -1;
    for (int i = 0; i < 160; i++) vram_m[i] = -1;
    last_m            = 12'hFFF;
    memory_addr       = 12'h000;
    memory_write_en   = 1'b0;
    memory_write_data = 4'h0;
    video_addr        = 8'd200;
    io_read_data      = 4'h0;
    reset_n           = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("reset_read_data", 12'(memory_read_data), 12'h0);
    check("reset_video_data", 12'(video_data), 12'h0);
    check("reset_strobe", 12'(io_read_strobe), 12'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;

    // General RAM and unmapped space
    step(12'h27F, 1, 4'h9, 8'd200, 4'h0);
    step(12'h000, 1, 4'h5, 8'd200, 4'h0);
    step(12'h280, 1, 4'hF, 8'd200, 4'h0);
    step(12'h27F, 0, 4'h0, 8'd200, 4'h0);
    step(12'h000, 0, 4'h0, 8'd200, 4'h0);
    step(12'h280, 0, 4'h0, 8'd200, 4'h0);

    // VRAM banks through both ports
    step(12'hE00, 1, 4'hA, 8'd200, 4'h0);
    step(12'hE4F, 1, 4'hB, 8'd200, 4'h0);
    step(12'hE80, 1, 4'hC, 8'd200, 4'h0);
    step(12'hECF, 1, 4'hD, 8'd200, 4'h0);
    step(12'hE50, 0, 4'h0, 8'd0,   4'h0);
    step(12'hED0, 0, 4'h0, 8'd79,  4'h0);
    step(12'hE4F, 0, 4'h0, 8'd80,  4'h0);
    step(12'hECF, 0, 4'h0, 8'd159, 4'h0);
    step(12'hE00, 0, 4'h0, 8'd160, 4'h0);

    // Read-during-write on both ports
    step(12'h100, 1, 4'h3, 8'd200, 4'h0);
    step(12'h100, 1, 4'h7, 8'd200, 4'h0);
    step(12'h100, 0, 4'h0, 8'd200, 4'h0);
    step(12'hE05, 1, 4'h2, 8'd200, 4'h0);
    step(12'hE05, 1, 4'h9, 8'd5,   4'h0);
    step(12'h005, 0, 4'h0, 8'd5,   4'h0);

    // I/O window: write forwarding, held read, back-to-back address changes
    step(12'hF12, 1, 4'h6, 8'd200, 4'h1);
    step(12'hF00, 0, 4'h0, 8'd200, 4'hE);
    step(12'hF00, 0, 4'h0, 8'd200, 4'hE);
    step(12'hF00, 0, 4'h0, 8'd200, 4'hE);
    step(12'hF01, 0, 4'h0, 8'd200, 4'h4);
    step(12'h005, 0, 4'h0, 8'd200, 4'h4);
    step(12'hF01, 0, 4'h0, 8'd0,   4'h8);

    // Asynchronous reset mid-sequence, with all outputs non-zero beforehand
    reset_n = 1'b0;
    #1;
    check("async_read_data", 12'(memory_read_data), 12'h0);
    check("async_video_data", 12'(video_data), 12'h0);
    check("async_strobe", 12'(io_read_strobe), 12'h0);
    last_m = 12'hFFF;
    memory_addr     = 12'hF00;
    memory_write_en = 1'b0;
    @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    step(12'hF00, 0, 4'h3, 8'd200, 4'h3);
    step(12'h000, 0, 4'h0, 8'd200, 4'h0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      step(rand_addr(), 1'($urandom_range(0, 2) == 0), 4'($urandom),
           rand_vaddr(), 4'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
